// File: rtl/count_history_scan_pkg.sv
// Shared constants and types for the counter-history display scanner.
package count_history_scan_pkg;
    localparam int DIGITS = 8;
    localparam int SEG_W  = 7;
    localparam int IDX_W  = 3;
    localparam int FILL_W = 4;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // History occupancy only ever grows, capped at the display depth.
    function automatic logic [FILL_W-1:0] fill_inc(input logic [FILL_W-1:0] f);
        return (f == FILL_W'(DIGITS)) ? f : f + 1'b1;
    endfunction
endpackage

// File: rtl/count_history_scan_if.sv
// Counter sample inputs and multiplexed 7-segment display outputs.
interface count_history_scan_if;
    import count_history_scan_pkg::*;

    logic [2:0]        iQ;
    seg_t              iDisplay;
    seg_t              oSeg;
    logic              oDP;
    logic [DIGITS-1:0] oAn;
    logic [FILL_W-1:0] oFill;

    modport master (output iQ, iDisplay, input  oSeg, oDP, oAn, oFill);
    modport slave  (input  iQ, iDisplay, output oSeg, oDP, oAn, oFill);
endinterface

// File: rtl/count_history_scan_scan_tick.sv
// Digit-scan prescaler: holds each digit index for SCAN_DIV cycles, wrapping 0..DIGITS-1.
module count_history_scan_scan_tick
    import count_history_scan_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic             CLK,
    input  logic             rst,
    output logic [IDX_W-1:0] idx
);
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0] presc;
    logic          adv;

    assign adv = (presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else begin
            presc <= adv ? '0 : presc + 1'b1;
            if (adv)
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/count_history_scan.sv
// Samples the counter, keeps a history of the last DIGITS distinct values and
// scans them onto a common-anode display, newest value on digit 0.
module count_history_scan
    import count_history_scan_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic                  CLK,
    input  logic                  rst,
    count_history_scan_if.slave   bus
);
    logic [2:0]        q_s, q_p;
    seg_t              pat_s;
    logic              s_vld, have_prev;
    seg_t              hist [DIGITS];
    logic [FILL_W-1:0] fill;
    logic [IDX_W-1:0]  idx;
    logic              push;
    seg_t              seg_r;
    logic              dp_r;
    logic [DIGITS-1:0] an_r;

    count_history_scan_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .CLK (CLK),
        .rst (rst),
        .idx (idx)
    );

    // s_vld keeps the reset value of q_s/pat_s from being pushed as a real sample.
    assign push = s_vld && (!have_prev || (q_s != q_p));

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            q_s   <= '0;
            q_p   <= '0;
            pat_s <= SEG_BLANK;
            s_vld <= 1'b0;
        end else begin
            q_s   <= bus.iQ;
            pat_s <= bus.iDisplay;
            q_p   <= q_s;
            s_vld <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++)
                hist[i] <= SEG_BLANK;
            fill      <= '0;
            have_prev <= 1'b0;
        end else if (push) begin
            hist[0] <= pat_s;
            for (int i = 1; i < DIGITS; i++)
                hist[i] <= hist[i-1];
            fill      <= fill_inc(fill);
            have_prev <= 1'b1;
        end
    end

    // Anode and segments come from the same idx on the same edge, so a push
    // landing on a digit advance never shows a mismatched digit.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
            an_r  <= '1;
        end else begin
            an_r  <= ~(DIGITS'(1) << idx);
            seg_r <= ({1'b0, idx} < fill) ? hist[idx] : SEG_BLANK;
            dp_r  <= !((idx == '0) && (fill != '0));
        end
    end

    assign bus.oSeg  = seg_r;
    assign bus.oDP   = dp_r;
    assign bus.oAn   = an_r;
    assign bus.oFill = fill;
endmodule

// File: tb/tb_count_history_scan.sv
// Directed bench for count_history_scan with a 4-cycle digit scan period.
module tb_count_history_scan;
    import count_history_scan_pkg::*;

    logic CLK = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errors  = 0;
    seg_t pat [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    count_history_scan_if bus ();

    count_history_scan #(.SCAN_DIV(4)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_q(input int v);
        bus.iQ       = 3'(v);
        bus.iDisplay = pat[v];
        step(20);
    endtask

    task automatic digit(input int k, input seg_t seg, input logic dp);
        logic [7:0] target;
        target = ~(8'd1 << k);
        for (int i = 0; i < 40 && bus.oAn !== target; i++)
            step(1);
        chk($sformatf("an_d%0d", k), bus.oAn, target);
        chk($sformatf("seg_d%0d", k), {1'b0, bus.oSeg}, {1'b0, seg});
        chk($sformatf("dp_d%0d", k), {7'd0, bus.oDP}, {7'd0, dp});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_seg"},  {1'b0, bus.oSeg}, 8'h7F);
        chk({tag, "_an"},   bus.oAn, 8'hFF);
        chk({tag, "_dp"},   {7'd0, bus.oDP}, 8'h01);
        chk({tag, "_fill"}, {4'd0, bus.oFill}, 8'h00);
    endtask

    initial begin
        rst          = 1'b1;
        bus.iQ       = 3'd2;
        bus.iDisplay = pat[2];
        #2;
        chk_reset("por");

        // first session: history 2..6, used to set up a mid-scan reset with fill 5
        step(1);
        rst = 1'b0;
        step(1);
        chk("fill_first_edge", {4'd0, bus.oFill}, 8'd0);
        step(1);
        chk("fill_second_edge", {4'd0, bus.oFill}, 8'd1);
        for (int v = 3; v <= 6; v++) set_q(v);
        chk("fill5", {4'd0, bus.oFill}, 8'd5);
        digit(0, pat[6], 1'b0);
        digit(4, pat[2], 1'b1);
        digit(5, SEG_BLANK, 1'b1);

        step(1);
        rst = 1'b1;
        #1;
        chk_reset("midrst");

        // restart with iQ=0, equal to the reset value of the sample registers
        bus.iQ       = 3'd0;
        bus.iDisplay = pat[0];
        step(2);
        rst = 1'b0;
        step(1);
        chk("refill_first_edge", {4'd0, bus.oFill}, 8'd0);
        step(1);
        chk("refill_second_edge", {4'd0, bus.oFill}, 8'd1);
        step(2);
        digit(0, pat[0], 1'b0);
        for (int k = 1; k < 8; k++) digit(k, SEG_BLANK, 1'b1);

        for (int v = 1; v <= 7; v++) set_q(v);
        chk("fill8", {4'd0, bus.oFill}, 8'd8);
        for (int k = 0; k < 8; k++) digit(k, pat[7-k], k == 0 ? 1'b0 : 1'b1);

        set_q(0);
        chk("fill_sat", {4'd0, bus.oFill}, 8'd8);
        digit(0, pat[0], 1'b0);
        digit(6, pat[2], 1'b1);
        digit(7, pat[1], 1'b1);

        // anode sequence: sync to the first cycle of FE, then each code for exactly 4 cycles
        for (int i = 0; i < 40 && bus.oAn !== 8'h7F; i++) step(1);
        for (int i = 0; i < 8 && bus.oAn !== 8'hFE; i++) step(1);
        for (int d = 0; d < 9; d++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("scan_%0d_%0d", d, c), bus.oAn, ~(8'd1 << (d % 8)));
                step(1);
            end
        end
        chk("scan_next", bus.oAn, 8'hFD);

        // only iDisplay moves while iQ holds at 3: history must not shift
        set_q(3);
        for (int i = 0; i < 200; i++) begin
            bus.iDisplay = 7'($urandom_range(0, 127));
            step(1);
        end
        chk("fill_hold", {4'd0, bus.oFill}, 8'd8);
        digit(0, pat[3], 1'b0);
        digit(1, pat[0], 1'b1);
        digit(2, pat[7], 1'b1);
        digit(3, pat[6], 1'b1);
        digit(7, pat[2], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
